sum_accumulator: RTL and testbench

- Downstream consumer of the 32-bit signed adder's 33-bit signed SUM.
- Accumulates a block of COUNT consecutive sums into a wider signed accumulator and emits one result per block.
- Uses valid/ready handshakes on both sides and flags signed overflow.
- Used in the adder benches to produce a registered, comparable signature of each adder's output stream.

---
 rtl/sum_accumulator.sv | 117 +++++++++++
 tb/tb_sum_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Block accumulator for signed adder sums: adds COUNT accepted samples into a
// wrapping ACC_W-bit accumulator and presents one result (with overflow flag) per block.
module sum_accumulator #(
  parameter int IN_W  = 33,
  parameter int ACC_W = 40,
  parameter int COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  SUM_IN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    CLR,
  output logic signed [ACC_W-1:0] ACC_OUT,
  output logic                    OVF,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_acc_q, ovf_acc_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] sx, nxt;
  logic                    accept, ovf_step;

  function automatic logic signed [ACC_W-1:0] sign_ext(input logic signed [IN_W-1:0] v);
    return ACC_W'(v);
  endfunction

  // Two's-complement overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign in_ready = (state_q == ACCUM) && !CLR;
  assign accept   = in_valid && in_ready;
  assign sx       = sign_ext(SUM_IN);
  assign nxt      = acc_q + sx;
  assign ovf_step = add_ovf(acc_q, sx, nxt);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (CLR) begin
          acc_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (accept) begin
          if (cnt_q == LAST) begin
            acc_out_d   = nxt;
            ovf_d       = ovf_acc_q | ovf_step;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d     = nxt;
            cnt_d     = cnt_q + CNT_W'(1);
            ovf_acc_d = ovf_acc_q | ovf_step;
          end
        end
      end
      HOLD: begin
        // Partial state is already zero here, so CLR has nothing to discard.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ACC_OUT   = acc_out_q;
  assign OVF       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: four parameterisations driven by directed and random
// stimulus, checked every cycle against a block-sum reference model.
`timescale 1ns/1ps
module tb_sum_accumulator;

  localparam int NI = 4;
  // Instance 2 uses ACC_W=33 so two maximum positive sums wrap to -2.
  localparam logic [NI-1:0][7:0] CNT = {8'd1, 8'd2, 8'd2, 8'd4};
  localparam logic [NI-1:0][7:0] AWS = {8'd34, 8'd33, 8'd40, 8'd40};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst       [NI];
  logic              in_valid  [NI];
  logic              in_ready  [NI];
  logic              clr       [NI];
  logic              ovf       [NI];
  logic              out_valid [NI];
  logic              out_ready [NI];
  logic signed [32:0] sum_in   [NI];
  longint            acc_s     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic signed [int'(AWS[g])-1:0] ao;
    sum_accumulator #(
      .IN_W (33),
      .ACC_W(int'(AWS[g])),
      .COUNT(int'(CNT[g]))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .SUM_IN   (sum_in[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .CLR      (clr[g]),
      .ACC_OUT  (ao),
      .OVF      (ovf[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g])
    );
    assign acc_s[g] = longint'(ao);
  end

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  bit     m_hold [NI];
  int     m_n    [NI];
  longint m_run  [NI];
  bit     m_rovf [NI];
  longint m_acc  [NI];
  bit     m_ovf  [NI];

  function automatic longint wrap(input longint t, input int w);
    longint m;
    m = t & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic logic signed [32:0] rnd_sum();
    logic signed [32:0] r;
    case ($urandom_range(0, 4))
      0:       r = 33'sh1_0000_0000;
      1:       r = 33'sh0_FFFF_FFFF;
      default: r = {1'($urandom_range(0, 1)), 32'($urandom)};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input longint v);
    int k;
    k = 0;
    sum_in[i]   = v[32:0];
    in_valid[i] = 1'b1;
    #1;
    while (in_ready[i] !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    if (k == 40) chk($sformatf("send_timeout%0d", i), in_ready[i], 1);
    step();
    in_valid[i] = 1'b0;
  endtask

  task automatic chk_out(input string name, input int i, input longint acc, input bit ov);
    chk({name, "_valid"}, out_valid[i], 1);
    chk({name, "_acc"}, acc_s[i], acc);
    chk({name, "_ovf"}, ovf[i], ov);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; clr[i] = 1'b0;
      out_ready[i] = 1'b1; sum_in[i] = '0;
      m_hold[i] = 1'b0; m_n[i] = 0; m_run[i] = 0; m_rovf[i] = 1'b0;
      m_acc[i] = 0; m_ovf[i] = 1'b0;
    end

    fork
      begin : model
        longint t, lim;
        forever begin
          @(posedge clk);
          for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
              m_hold[i] = 1'b0; m_n[i] = 0; m_run[i] = 0; m_rovf[i] = 1'b0;
              m_acc[i] = 0; m_ovf[i] = 1'b0;
            end else if (m_hold[i]) begin
              if (out_ready[i]) m_hold[i] = 1'b0;
            end else if (clr[i]) begin
              m_n[i] = 0; m_run[i] = 0; m_rovf[i] = 1'b0;
            end else if (in_valid[i]) begin
              t   = m_run[i] + longint'(sum_in[i]);
              lim = 64'sd1 <<< (int'(AWS[i]) - 1);
              if (t >= lim || t < -lim) m_rovf[i] = 1'b1;
              m_run[i] = wrap(t, int'(AWS[i]));
              m_n[i]++;
              if (m_n[i] == int'(CNT[i])) begin
                m_acc[i]  = m_run[i];
                m_ovf[i]  = m_rovf[i];
                m_hold[i] = 1'b1;
                m_n[i] = 0; m_run[i] = 0; m_rovf[i] = 1'b0;
              end
            end
          end
        end
      end
      begin : compare
        forever begin
          @(negedge clk);
          if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
              chk($sformatf("in_ready%0d", i), in_ready[i], !m_hold[i] && !clr[i]);
              chk($sformatf("out_valid%0d", i), out_valid[i], m_hold[i]);
              if (m_hold[i]) begin
                chk($sformatf("acc%0d", i), acc_s[i], m_acc[i]);
                chk($sformatf("ovf%0d", i), ovf[i], m_ovf[i]);
              end
            end
          end
        end
      end
    join_none

    step();
    step();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    #1;
    cmp_en = 1'b1;
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_acc", acc_s[0], 0);
    chk("rst_ovf", ovf[0], 0);

    // Basic block, COUNT=4
    send(0, 10); send(0, -3); send(0, 100); send(0, 64'sd4294967295);
    chk_out("basic", 0, 64'sd4294967402, 1'b0);
    chk("basic_hold_in_ready", in_ready[0], 0);
    step();
    chk("basic_taken_valid", out_valid[0], 0);
    chk("basic_taken_in_ready", in_ready[0], 1);

    // CLR mid-block drops the coincident sample
    send(0, 5); send(0, 6);
    clr[0] = 1'b1; in_valid[0] = 1'b1; sum_in[0] = 33'sd9;
    #1;
    chk("clr_in_ready", in_ready[0], 0);
    step();
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    chk_out("clr_block", 0, 10, 1'b0);
    step();

    // Reset while a result is held
    out_ready[0] = 1'b0;
    send(0, 40); send(0, 1); send(0, 1); send(0, 0);
    chk_out("hold42", 0, 42, 1'b0);
    step(); step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rsthold_valid", out_valid[0], 0);
    chk("rsthold_acc", acc_s[0], 0);
    chk("rsthold_ovf", ovf[0], 0);
    chk("rsthold_in_ready", in_ready[0], 1);
    out_ready[0] = 1'b1;
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    chk_out("after_rst", 0, 4, 1'b0);
    step();

    // Negative extremes, COUNT=2
    send(1, -64'sd4294967296); send(1, -64'sd4294967296);
    chk_out("negmin", 1, -64'sd8589934592, 1'b0);
    step();

    // Backpressure: 77 waits on SUM_IN until the result is taken
    out_ready[1] = 1'b0;
    send(1, 7); send(1, 8);
    sum_in[1] = 33'sd77; in_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out("bp_hold", 1, 15, 1'b0);
      chk("bp_in_ready", in_ready[1], 0);
    end
    out_ready[1] = 1'b1;
    step();
    chk("bp_release_valid", out_valid[1], 0);
    chk("bp_release_in_ready", in_ready[1], 1);
    step();
    in_valid[1] = 1'b0;
    send(1, 3);
    chk_out("bp_next", 1, 80, 1'b0);
    step();

    // Wrap with ACC_W=33, COUNT=2; sticky flag clears per block
    send(2, 64'sd4294967295); send(2, 64'sd4294967295);
    chk_out("wrap", 2, -2, 1'b1);
    step();
    send(2, 1); send(2, 1);
    chk_out("wrap_next", 2, 2, 1'b0);
    step();

    // COUNT=1, ACC_W=34: each sample is its own block
    send(3, -64'sd4294967296);
    chk_out("count1", 3, -64'sd4294967296, 1'b0);
    step();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        clr[i]       = ($urandom_range(0, 29) == 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        rst[i]       = ($urandom_range(0, 399) == 0);
        sum_in[i]    = rnd_sum();
      end
      step();
    end
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; clr[i] = 1'b0; rst[i] = 1'b0; out_ready[i] = 1'b1;
    end
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
